// File: rtl/line_mem_ctrl_pkg.sv
// Types and constants shared by the cache and the line memory controller.
// RW encoding and the request struct must stay identical on both sides.
package line_mem_ctrl_pkg;

  localparam int LINE_BITS       = 256;
  localparam int BLOCK_ADDR_BITS = 15;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  typedef struct packed {
    logic                       rw;
    logic [BLOCK_ADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0]       wdata;
  } mem_req_t;

  localparam int MEM_REQ_BITS = $bits(mem_req_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } eng_state_e;

endpackage

// File: rtl/line_mem_ctrl_req_fifo.sv
// In-order request queue; pop is combinational from the head slot, zero-cycle latency.
// Push while full is ignored unless a pop frees the slot on the same edge.
module req_fifo #(
  parameter int WIDTH = 272,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = slots[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line-granular backing memory: queues cache requests, services one at a time with fixed latency.
// No backpressure upstream: requests arriving on a full queue are dropped and flagged sticky.
module line_mem_ctrl
  import line_mem_ctrl_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int IDX_BITS  = 10,
  parameter int QDEPTH    = 4,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_req_valid,
  input  logic                       mem_req_rw,
  input  logic [BLOCK_ADDR_BITS-1:0] mem_req_addr,
  input  logic [LINE_BITS-1:0]       mem_req_wdata,
  output logic                       mem_resp_valid,
  output logic [LINE_BITS-1:0]       mem_resp_rdata,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic                       busy,
  output logic                       overflow
);

  localparam int CNT_W = $clog2((RD_LAT > WR_LAT) ? RD_LAT : WR_LAT);

  mem_req_t            req_in, fifo_head, eng_q, eng_d;
  eng_state_e          state_q, state_d;
  logic [CNT_W-1:0]    lat_q, lat_d;
  logic                resp_vld_q, resp_vld_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                ovf_q, ovf_d;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                take_in, wr_en;
  logic [LINE_BITS-1:0] lines [MEM_LINES];
  logic                unused_addr;

  function automatic logic [CNT_W-1:0] load_lat(input logic rw);
    return (rw == MEM_WR) ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
  endfunction

  assign req_in      = '{rw: mem_req_rw, addr: mem_req_addr, wdata: mem_req_wdata};
  // Address bits above the index alias onto the same line.
  assign unused_addr = ^eng_q.addr;

  req_fifo #(
    .WIDTH (MEM_REQ_BITS),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (req_in),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  always_comb begin
    state_d    = state_q;
    eng_d      = eng_q;
    lat_d      = lat_q;
    resp_vld_d = 1'b0;
    rdata_d    = rdata_q;
    fifo_pop   = 1'b0;
    take_in    = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          eng_d    = fifo_head;
          lat_d    = load_lat(fifo_head.rw);
          state_d  = ST_BUSY;
        end else if (mem_req_valid) begin
          // Empty engine and queue: start the new request on its accept edge.
          take_in = 1'b1;
          eng_d   = req_in;
          lat_d   = load_lat(mem_req_rw);
          state_d = ST_BUSY;
        end
      end
      default: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          if (eng_q.rw == MEM_RD) begin
            resp_vld_d = 1'b1;
            rdata_d    = lines[eng_q.addr[IDX_BITS-1:0]];
          end else begin
            wr_en = 1'b1;
          end
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            eng_d    = fifo_head;
            lat_d    = load_lat(fifo_head.rw);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
    fifo_push = mem_req_valid && !take_in && (!fifo_full || fifo_pop);
    ovf_d     = ovf_q || (mem_req_valid && !take_in && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      eng_q      <= '0;
      lat_q      <= '0;
      resp_vld_q <= 1'b0;
      rdata_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      eng_q      <= eng_d;
      lat_q      <= lat_d;
      resp_vld_q <= resp_vld_d;
      rdata_q    <= rdata_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en) lines[eng_q.addr[IDX_BITS-1:0]] <= eng_q.wdata;
  end

  assign mem_resp_valid = resp_vld_q;
  assign mem_resp_rdata = rdata_q;
  assign overflow       = ovf_q;
  assign busy           = (state_q != ST_IDLE) || (q_count != '0);

endmodule
